pcileech_rst_led_seq: RTL and testbench
=======================================

# pcileech_rst_led_seq

Parametrised reset sequencer and status-LED controller for the board top level. Replaces the fixed 16-stage PERST# shift-register reset and the direct LED assigns. It synchronises the PERST# pad and releases N reset domains in a staggered order. It drives M active-low LEDs with per-LED modes (off, on, slow blink, fast blink), and an identify signal overrides all LED modes.

## Interface
Parameters:
- NUM_DOMAINS, 2: number of reset outputs (1..8); domain 0 is released first.
- RST_HOLD_CYCLES, 16: consecutive synchronised-high PERST# cycles required before domain 0 is released (≥1).
- STAGGER_CYCLES, 8: cycles between consecutive domain releases (≥1).
- NUM_LEDS, 2: number of LED outputs (1..8).
- BLINK_DIV_LOG2, 24: blink prescaler width (≥4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  block reset. One clock; reset is synchronous and active-low.
- perst_n_in  in  1  PERST# pad, asynchronous to clk, active-low.
- led_mode  in  2*NUM_LEDS  per-LED mode: 0 off, 1 on, 2 slow blink, 3 fast blink. LED i uses bits [2i+1:2i].
- led_identify  in  1  forces all LEDs to fast blink.
- rst_dom_out  out  NUM_DOMAINS  active-high domain resets.
- rst_done  out  1  high once all domains are released.
- led_n  out  NUM_LEDS  active-low LED drives.

## Operation
- Reset values while rst_n is low: rst_dom_out all 1; rst_done 0; led_n all 1; state S_RESET; all counters 0; synchroniser flops 0 (treated as PERST# asserted).
- perst_n_in passes through a 2-flop synchroniser to produce perst_s.
- FSM states:
  - S_RESET: rst_dom_out all 1, rst_done 0. Move to S_HOLD when perst_s = 1.
  - S_HOLD: hold_cnt increments each cycle that perst_s = 1. When hold_cnt = RST_HOLD_CYCLES−1, release domain 0 and go to S_STAGGER, or go to S_RUN if NUM_DOMAINS = 1.
  - S_STAGGER: stg_cnt counts to STAGGER_CYCLES−1, then releases the next domain and clears. After the last domain is released, go to S_RUN.
  - S_RUN: rst_dom_out all 0, rst_done 1.
- From any state, perst_s = 0 forces the next state to S_RESET, sets rst_dom_out all 1 and rst_done 0, and clears all counters. This takes priority over a release scheduled in the same cycle.
- Releases are monotonic: rst_dom_out[k] never falls before rst_dom_out[k−1].
- rst_done rises in the same cycle that the last domain is released.
- Blink prescaler: a free-running BLINK_DIV_LOG2-bit counter reset to 0 that wraps modulo 2^BLINK_DIV_LOG2.
  - slow = bit [BLINK_DIV_LOG2−1]
  - fast = bit [BLINK_DIV_LOG2−3]
- LED i on-condition: led_identify ? fast : (mode 0 → 0, 1 → 1, 2 → slow, 3 → fast).
- led_n[i] is the registered inverse of the on-condition.
- The LED path is independent of PERST#. It runs whenever rst_n is high.

## Timing
- Release latency: rst_dom_out[0] falls exactly 3 + RST_HOLD_CYCLES clk edges after the first edge that samples perst_n_in high (2 synchroniser + HOLD count + 1 register).
- Subsequent domains: rst_dom_out[k] falls k·STAGGER_CYCLES edges after domain 0.
- Assertion latency: rst_dom_out goes all 1 exactly 3 edges after the first edge sampling perst_n_in low.
- Glitches: a PERST# high pulse shorter than RST_HOLD_CYCLES releases nothing and returns the FSM to S_RESET. A PERST# low pulse of at least 1 synchronised cycle in any state re-asserts all domains.
- LED latency: 1 cycle from a led_mode, led_identify or prescaler-bit change to led_n.
- Blink periods: slow = 2^BLINK_DIV_LOG2 cycles; fast = 2^(BLINK_DIV_LOG2−2) cycles; both 50 % duty.
- rst_n low mid-sequence: the next edge restores all reset values, regardless of PERST#.

## Structure
- Shared package pcileech_rst_pkg holds:
  - enum state_t {S_RESET, S_HOLD, S_STAGGER, S_RUN};
  - enum led_mode_t {LED_OFF, LED_ON, LED_SLOW, LED_FAST}.
- Sub-module pcileech_sync2: 2-flop synchroniser with synchronous active-low reset value 0. Reused for other pad inputs.
- Counter widths are $clog2 of their terminal values plus 1.

## Test plan
- NUM_DOMAINS=2, HOLD=16, STAGGER=8. perst_n_in rises at edge 0 → rst_dom_out[0] falls at edge 19, rst_dom_out[1] falls at edge 27, rst_done rises at edge 27.
- perst_n_in high for 10 cycles, then low for 1 cycle, then high → no domain released during the first pulse; release completes at the new edge 0 + 19/27.
- In S_RUN, perst_n_in falls at edge 0 → rst_dom_out = 2'b11 and rst_done = 0 at edge 3.
- BLINK_DIV_LOG2=4, led_mode = {LED_FAST, LED_SLOW} → led_n[0] toggles every 8 cycles and led_n[1] toggles every 2 cycles. Asserting led_identify → both LEDs toggle every 2 cycles starting 1 cycle later.
- rst_n pulsed low mid-S_STAGGER → on the next edge rst_dom_out is all 1, rst_done is 0 and led_n is all 1; then the full release sequence reruns from edge 0.
- NUM_DOMAINS=1 → rst_dom_out[0] and rst_done both change at edge 19; S_STAGGER is never entered.

Source files
------------

// File: rtl/pcileech_rst_pkg.sv
// Shared types for the PCIe reset sequencer and LED controller.
//   state_t    : reset sequencer FSM states
//   led_mode_t : per-LED drive mode encoding on led_mode
//   led_on()   : on-condition for one LED given its mode and blink phases
package pcileech_rst_pkg;

    typedef enum logic [1:0] {
        S_RESET,
        S_HOLD,
        S_STAGGER,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        LED_OFF,
        LED_ON,
        LED_SLOW,
        LED_FAST
    } led_mode_t;

    function automatic logic led_on(input logic [1:0] mode,
                                    input logic       slow,
                                    input logic       fast);
        logic on;
        case (mode)
            LED_OFF:  on = 1'b0;
            LED_ON:   on = 1'b1;
            LED_SLOW: on = slow;
            LED_FAST: on = fast;
            default:  on = 1'b0;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/pcileech_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs.
//   clk   : destination clock
//   rst_n : synchronous active-low reset, both flops reset to 0
//   d     : asynchronous input
//   q     : synchronised output (2 cycles of latency)
module pcileech_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pcileech_rst_led_seq.sv
// Reset sequencer and status-LED controller for the board top level.
//   clk          : system clock
//   rst_n        : synchronous active-low block reset
//   perst_n_in   : PERST# pad, asynchronous, active-low
//   led_mode     : 2 bits per LED (off / on / slow blink / fast blink)
//   led_identify : forces every LED to fast blink
//   rst_dom_out  : active-high domain resets, domain 0 released first
//   rst_done     : high once every domain is released
//   led_n        : active-low LED drives
//
// state     | meaning
// ----------+------------------------------------------------------
// S_RESET   | all domains held, waiting for synchronised PERST# high
// S_HOLD    | counting PERST# high cycles before releasing domain 0
// S_STAGGER | releasing remaining domains one per STAGGER_CYCLES
// S_RUN     | all domains released
module pcileech_rst_led_seq
    import pcileech_rst_pkg::*;
#(
    parameter int NUM_DOMAINS     = 2,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int STAGGER_CYCLES  = 8,
    parameter int NUM_LEDS        = 2,
    parameter int BLINK_DIV_LOG2  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  perst_n_in,
    input  logic [2*NUM_LEDS-1:0] led_mode,
    input  logic                  led_identify,
    output logic [NUM_DOMAINS-1:0] rst_dom_out,
    output logic                  rst_done,
    output logic [NUM_LEDS-1:0]   led_n
);

    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES) + 1;
    localparam int STG_W  = $clog2(STAGGER_CYCLES) + 1;
    localparam int REL_W  = $clog2(NUM_DOMAINS) + 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER_CYCLES - 1);
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(NUM_DOMAINS - 1);
    localparam logic [REL_W-1:0]  REL_ALL   = REL_W'(NUM_DOMAINS);

    logic perst_s;

    pcileech_sync2 u_perst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (perst_n_in),
        .q     (perst_s)
    );

    state_t             state, state_nx;
    logic [HOLD_W-1:0]  hold_cnt, hold_nx;
    logic [STG_W-1:0]   stg_cnt, stg_nx;
    // Number of domains released so far; domain k is out of reset when rel_cnt > k.
    logic [REL_W-1:0]   rel_cnt, rel_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_RESET;
            hold_cnt <= '0;
            stg_cnt  <= '0;
            rel_cnt  <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            stg_cnt  <= stg_nx;
            rel_cnt  <= rel_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        stg_nx   = stg_cnt;
        rel_nx   = rel_cnt;
        if (!perst_s) begin
            // PERST# low wins over any release due this cycle.
            state_nx = S_RESET;
            hold_nx  = '0;
            stg_nx   = '0;
            rel_nx   = '0;
        end else begin
            case (state)
                S_RESET: begin
                    state_nx = S_HOLD;
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nx  = '0;
                        rel_nx   = REL_W'(1);
                        state_nx = (NUM_DOMAINS == 1) ? S_RUN : S_STAGGER;
                    end else begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
                S_STAGGER: begin
                    if (stg_cnt == STG_LAST) begin
                        stg_nx = '0;
                        rel_nx = rel_cnt + 1'b1;
                        if (rel_cnt == REL_LAST) begin
                            state_nx = S_RUN;
                        end
                    end else begin
                        stg_nx = stg_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    state_nx = S_RUN;
                end
                default: begin
                    state_nx = S_RESET;
                end
            endcase
        end
    end

    // Outputs are registered from rel_cnt, so a release decided on one edge
    // reaches the pins on the next; rst_done moves together with the last domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_dom_out <= '1;
            rst_done    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_DOMAINS; k++) begin
                rst_dom_out[k] <= !(rel_cnt > REL_W'(k));
            end
            rst_done <= (rel_cnt == REL_ALL);
        end
    end

    // LED path: free-running prescaler, independent of PERST#.
    logic [BLINK_DIV_LOG2-1:0] blink_cnt;
    logic                      slow;
    logic                      fast;

    assign slow = blink_cnt[BLINK_DIV_LOG2-1];
    assign fast = blink_cnt[BLINK_DIV_LOG2-3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            led_n     <= '1;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            for (int i = 0; i < NUM_LEDS; i++) begin
                led_n[i] <= !led_on(led_identify ? LED_FAST : led_mode[2*i +: 2],
                                    slow, fast);
            end
        end
    end

endmodule

// File: tb/tb_pcileech_rst_led_seq.sv
module tb_pcileech_rst_led_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       perst_n_in;
    logic [3:0] led_mode;
    logic       led_identify;
    logic [1:0] rst_dom_out;
    logic       rst_done;
    logic [1:0] led_n;
    logic [0:0] rst_dom_out1;
    logic       rst_done1;
    logic [0:0] led_n1;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         at;
        int         sel;
        logic [7:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pcileech_rst_led_seq #(
        .NUM_DOMAINS(2), .RST_HOLD_CYCLES(16), .STAGGER_CYCLES(8),
        .NUM_LEDS(2), .BLINK_DIV_LOG2(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .perst_n_in(perst_n_in),
        .led_mode(led_mode), .led_identify(led_identify),
        .rst_dom_out(rst_dom_out), .rst_done(rst_done), .led_n(led_n)
    );

    pcileech_rst_led_seq #(
        .NUM_DOMAINS(1), .RST_HOLD_CYCLES(16), .STAGGER_CYCLES(8),
        .NUM_LEDS(1), .BLINK_DIV_LOG2(4)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .perst_n_in(perst_n_in),
        .led_mode(led_mode[1:0]), .led_identify(led_identify),
        .rst_dom_out(rst_dom_out1), .rst_done(rst_done1), .led_n(led_n1)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            0:       return {6'b0, rst_dom_out};
            1:       return {7'b0, rst_done};
            2:       return {6'b0, led_n};
            3:       return {7'b0, rst_dom_out1};
            4:       return {7'b0, rst_done1};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic push(input int at, input int sel, input logic [7:0] exp, input string tag);
        exp_t e;
        e.at  = at;
        e.sel = sel;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Scoreboard: compare every expectation due at this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                chk(sb[i].tag, obs(sb[i].sel), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic drain();
        int budget = 200;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        while (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: expectation never reached (due cycle %0d)", sb[0].tag, sb[0].at);
            sb.delete(0);
        end
    endtask

    // Full two-domain release starting at edge 'base'.
    task automatic push_release(input int base, input string pfx);
        push(base + 18, 0, 8'h03, {pfx, "_dom_pre"});
        push(base + 19, 0, 8'h02, {pfx, "_dom0_rel"});
        push(base + 26, 0, 8'h02, {pfx, "_dom1_pre"});
        push(base + 26, 1, 8'h00, {pfx, "_done_pre"});
        push(base + 27, 0, 8'h00, {pfx, "_dom1_rel"});
        push(base + 27, 1, 8'h01, {pfx, "_done"});
    endtask

    initial begin
        int base;
        int base2;
        int rst_edge;
        int d;

        rst_n        = 1'b0;
        perst_n_in   = 1'b0;
        led_mode     = 4'h0;
        led_identify = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dom", obs(0), 8'h03);
        chk("rst_done", obs(1), 8'h00);
        chk("rst_led", obs(2), 8'h03);
        chk("rst_dom1", obs(3), 8'h01);
        chk("rst_led1", {7'b0, led_n1}, 8'h01);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("perst_low_hold", obs(0), 8'h03);

        // Basic release; the single-domain instance sees the same PERST#.
        base = cyc + 1;
        push_release(base, "rel");
        push(base + 18, 3, 8'h01, "nd1_dom_pre");
        push(base + 18, 4, 8'h00, "nd1_done_pre");
        push(base + 19, 3, 8'h00, "nd1_dom_rel");
        push(base + 19, 4, 8'h01, "nd1_done");
        perst_n_in = 1'b1;
        drain();
        repeat (3) @(negedge clk);

        // PERST# falls in S_RUN.
        base = cyc + 1;
        push(base + 2, 0, 8'h00, "assert_pre");
        push(base + 2, 1, 8'h01, "assert_done_pre");
        push(base + 3, 0, 8'h03, "assert_dom");
        push(base + 3, 1, 8'h00, "assert_done");
        perst_n_in = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        // Short high pulse, 1-cycle low glitch, then a clean high.
        base = cyc + 1;
        perst_n_in = 1'b1;
        repeat (10) @(negedge clk);
        perst_n_in = 1'b0;
        @(negedge clk);
        perst_n_in = 1'b1;
        base2 = base + 11;
        push(base + 19, 0, 8'h03, "glitch_no_rel_a");
        push(base + 20, 0, 8'h03, "glitch_no_rel_b");
        push_release(base2, "glitch");
        drain();
        repeat (3) @(negedge clk);

        // rst_n pulsed low while in S_STAGGER.
        perst_n_in = 1'b0;
        led_mode   = 4'b0101;
        repeat (6) @(negedge clk);
        base = cyc + 1;
        perst_n_in = 1'b1;
        push(base + 21, 0, 8'h02, "mid_stg_dom");
        push(base + 21, 2, 8'h00, "mid_stg_led");
        push(base + 22, 0, 8'h03, "rstn_dom");
        push(base + 22, 1, 8'h00, "rstn_done");
        push(base + 22, 2, 8'h03, "rstn_led");
        push(base + 23, 2, 8'h00, "rstn_led_back");
        while (cyc < base + 21) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rst_edge = base + 22;
        push_release(base + 23, "rerun");
        drain();

        // Blink: LED0 slow, LED1 fast; prescaler is 0 after rst_edge.
        base = cyc + 1;
        led_mode = 4'b1110;
        for (int e = base; e < base + 20; e++) begin
            d = e - 1 - rst_edge;
            push(e, 2, {6'b0, ~((d & 2) != 0), ~((d & 8) != 0)}, "blink");
        end
        drain();
        base = cyc + 1;
        led_identify = 1'b1;
        for (int e = base; e < base + 12; e++) begin
            d = e - 1 - rst_edge;
            push(e, 2, {6'b0, ~((d & 2) != 0), ~((d & 2) != 0)}, "identify");
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
